// File: rtl/dqn_seq_pkg.sv
// Shared definitions for the DQN backprop sequencer.
//   state_t          : top-level FSM states (IDLE, RUN, DONE)
//   CTRL_IDLE        : controller code presented while no iteration runs
//   CTRL_DELTA_LATCH : controller code on which the delta/bias stage latches
//   STEP_W / CTRL_W  : widths of the step and controller buses
package dqn_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int STEP_W = 4;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_IDLE        = 4'd0;
    localparam logic [CTRL_W-1:0] CTRL_DELTA_LATCH = 4'd9;

endpackage

// File: rtl/dqn_dwell_cnt.sv
// Dwell counter: counts the cycles a phase code has been held.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (count returns to 0)
//   clr  : synchronous clear, has priority over en
//   en   : advance the count; wraps to 0 after DWELL-1
//   last : count is at DWELL-1 (the phase ends on the next enabled edge)
module dqn_dwell_cnt #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = $clog2(DWELL + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign last = (count_reg == CW'(DWELL - 1));

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = last ? '0 : count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/dqn_bp_sequencer.sv
// DQN backprop sequencer: on start, walks the controller code through
// 1..NUM_PHASES holding each for DWELL cycles, bumps step once per
// iteration and reports busy/done. Stall freezes the walk, abort ends it.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   start           : request an iteration (only honoured in IDLE)
//   stall, abort    : RUN-only controls, abort wins over stall
//   busy            : high while in RUN
//   done            : one-cycle pulse on normal completion
//   step            : iteration counter, wraps MAX_STEP -> 1
//   controller      : phase code, 0 when idle
//   phase_first     : first cycle of each presented phase code
//   iter_cycles     : RUN cycles of the last completed iteration
//                     (only with DQN_SEQ_CYCLE_CNT_EN defined)
// All outputs are registered.
module dqn_bp_sequencer
    import dqn_seq_pkg::*;
#(
    parameter int NUM_PHASES = 10,
    parameter int DWELL      = 4,
    parameter int MAX_STEP   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step,
    output logic [CTRL_W-1:0] controller,
    output logic              phase_first
`ifdef DQN_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]       iter_cycles
`endif
);

    state_t            state_reg, state_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              pf_reg, pf_next;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_last;

    dqn_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last)
    );

    always_comb begin
        state_next = state_reg;
        ctrl_next  = ctrl_reg;
        step_next  = step_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        pf_next    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ctrl_next = CTRL_IDLE;
                busy_next = 1'b0;
                cnt_clr   = 1'b1;
                if (start) begin
                    state_next = ST_RUN;
                    ctrl_next  = 4'd1;
                    pf_next    = 1'b1;
                    busy_next  = 1'b1;
                    // Incrementing on entry keeps step nonzero for the whole RUN.
                    step_next  = (step_reg == STEP_W'(MAX_STEP)) ? STEP_W'(1)
                                                                 : step_reg + STEP_W'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    ctrl_next  = CTRL_IDLE;
                    busy_next  = 1'b0;
                    cnt_clr    = 1'b1;
                end else if (!stall) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        if (ctrl_reg < CTRL_W'(NUM_PHASES)) begin
                            ctrl_next = ctrl_reg + CTRL_W'(1);
                            pf_next   = 1'b1;
                        end else begin
                            state_next = ST_DONE;
                            ctrl_next  = CTRL_IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
                cnt_clr    = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
                ctrl_next  = CTRL_IDLE;
                busy_next  = 1'b0;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ctrl_reg  <= CTRL_IDLE;
            step_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            pf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_next;
            step_reg  <= step_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            pf_reg    <= pf_next;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign step        = step_reg;
    assign controller  = ctrl_reg;
    assign phase_first = pf_reg;

`ifdef DQN_SEQ_CYCLE_CNT_EN
    logic [15:0] cyc_reg, cyc_next;
    logic [15:0] iter_reg, iter_next;
    logic [15:0] cyc_inc;

    assign cyc_inc = (cyc_reg == 16'hFFFF) ? cyc_reg : cyc_reg + 16'd1;

    always_comb begin
        cyc_next  = cyc_reg;
        iter_next = iter_reg;
        if (state_reg == ST_IDLE && start) begin
            cyc_next = '0;
        end else if (state_reg == ST_RUN) begin
            cyc_next = cyc_inc;
            // The completing RUN cycle is counted in the captured value.
            if (state_next == ST_DONE) begin
                iter_next = cyc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_reg  <= '0;
            iter_reg <= '0;
        end else begin
            cyc_reg  <= cyc_next;
            iter_reg <= iter_next;
        end
    end

    assign iter_cycles = iter_reg;
`endif

endmodule
